// File: rtl/ram_port_arb.sv
// Arbitrates a single-port RAM between a buffered write path and a host read port.
// Optional ARB_WR_PRIORITY_EN: pending writes always win over reads instead of alternating grants.
module ram_port_arb #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              overflow
);

    // state  | meaning
    // IDLE   | no RAM access, arbitration decided here
    // WR     | buffer head written to RAM at wr_ptr
    // RD     | RAM read issued at captured host address
    // RDATA  | read data returned to host with rd_ack
    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RDATA
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_buf [0:1];
    logic              r_head;
    logic [1:0]        r_count;
    logic [1:0]        w_count_nxt;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_last_wr;
    logic              r_overflow;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_tail;
    logic              w_pending;

    assign w_pop     = (r_state == S_WR);
    assign w_push    = wr_req && ((r_count != 2'd2) || w_pop);
    assign w_drop    = wr_req && (r_count == 2'd2) && !w_pop;
    // With two entries the tail slot equals head when full, which is the slot freed by a concurrent pop.
    assign w_tail    = r_head ^ r_count[0];
    assign w_pending = (r_count != 2'd0);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
`ifdef ARB_WR_PRIORITY_EN
                if (w_pending)
                    w_state_nxt = S_WR;
                else if (rd_req)
                    w_state_nxt = S_RD;
`else
                if (w_pending && (!rd_req || !r_last_wr))
                    w_state_nxt = S_WR;
                else if (rd_req)
                    w_state_nxt = S_RD;
`endif
            end
            S_WR:    w_state_nxt = S_IDLE;
            S_RD:    w_state_nxt = S_RDATA;
            S_RDATA: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_head     <= 1'b0;
            r_count    <= 2'd0;
            r_wr_ptr   <= '0;
            r_rd_addr  <= '0;
            r_last_wr  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_pop) begin
                r_head    <= ~r_head;
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                r_last_wr <= 1'b1;
            end
            if (r_state == S_RDATA)
                r_last_wr <= 1'b0;
            if ((r_state == S_IDLE) && (w_state_nxt == S_RD))
                r_rd_addr <= rd_addr;
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    // Buffer storage needs no reset; r_count qualifies its contents.
    always_ff @(posedge clk) begin
        if (w_push)
            r_buf[w_tail] <= wr_data;
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        rd_ack    = 1'b0;
        rd_data   = '0;
        case (r_state)
            S_WR: begin
                ram_we    = 1'b1;
                ram_addr  = r_wr_ptr;
                ram_wdata = r_buf[r_head];
            end
            S_RD: begin
                ram_re   = 1'b1;
                ram_addr = r_rd_addr;
            end
            S_RDATA: begin
                rd_ack  = 1'b1;
                rd_data = ram_rdata;
            end
            default: ;
        endcase
    end

    assign wr_ptr   = r_wr_ptr;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_ram_port_arb.sv
// Directed bench for ram_port_arb with a behavioural single-port RAM model.
module tb_ram_port_arb;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_req;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [2:0] rd_addr;
    logic       rd_ack;
    logic [7:0] rd_data;
    logic       ram_we;
    logic       ram_re;
    logic [2:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = 8'h00;
    logic [2:0] wr_ptr;
    logic       overflow;

    logic [7:0] mem [0:7] = '{8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00};

    int n_checks = 0;
    int n_fail   = 0;

    ram_port_arb #(.ADDR_W(3), .DATA_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .wr_ptr    (wr_ptr),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        if (ram_re)
            ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        logic       wr_req;
        logic [7:0] wr_data;
        logic       rd_req;
        logic [2:0] rd_addr;
        logic       e_we;
        logic       e_re;
        logic [2:0] e_addr;
        logic [7:0] e_wd;
        logic       e_ack;
        logic [7:0] e_rd;
        logic [2:0] e_ptr;
        logic       e_ovf;
    } vec_t;

    vec_t vecs [0:6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic we, input logic re, input logic [2:0] addr,
                       input logic [7:0] wd, input logic ack, input logic [7:0] rdv,
                       input logic [2:0] ptr, input logic ovf);
        logic [25:0] act;
        logic [25:0] exp;
        act = {ram_we, ram_re, ram_addr, ram_wdata, rd_ack, rd_data, wr_ptr, overflow};
        exp = {we, re, addr, wd, ack, rdv, ptr, ovf};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got we=%0b re=%0b addr=%0d wdata=%h ack=%0b rdata=%h ptr=%0d ovf=%0b, expected we=%0b re=%0b addr=%0d wdata=%h ack=%0b rdata=%h ptr=%0d ovf=%0b",
                     nm, ram_we, ram_re, ram_addr, ram_wdata, rd_ack, rd_data, wr_ptr, overflow,
                     we, re, addr, wd, ack, rdv, ptr, ovf);
        end
    endtask

    task automatic chk_mem(input string nm, input int idx, input logic [7:0] exp);
        n_checks++;
        if (mem[idx] !== exp) begin
            n_fail++;
            $display("FAIL %s: RAM[%0d]=%h, expected %h", nm, idx, mem[idx], exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        wr_req  = 1'b0;
        wr_data = 8'h00;
        rd_req  = 1'b0;
        rd_addr = 3'd0;

        //             wr  data   rd  addr  we  re  addr wdata  ack rdata  ptr ovf
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 8'hA5, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 3'd1, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 3'd3, 1'b0, 1'b1, 3'd3, 8'h00, 1'b0, 8'h00, 3'd1, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 8'h3C, 3'd1, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 3'd1, 1'b0};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_re, vecs[i].e_addr, vecs[i].e_wd,
                vecs[i].e_ack, vecs[i].e_rd, vecs[i].e_ptr, vecs[i].e_ovf);
            wr_req  = vecs[i].wr_req;
            wr_data = vecs[i].wr_data;
            rd_req  = vecs[i].rd_req;
            rd_addr = vecs[i].rd_addr;
            step();
        end
        chk_mem("first_write", 0, 8'hA5);

        // Write pending together with a read while last grant was a write.
        wr_req = 1'b1; wr_data = 8'h11; step();
        wr_data = 8'h22; step();
        chk("cont_wr1", 1'b1, 1'b0, 3'd1, 8'h11, 1'b0, 8'h00, 3'd1, 1'b0);
        wr_req = 1'b0; rd_req = 1'b1; rd_addr = 3'd0; step();
        chk("cont_idle", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 3'd2, 1'b0);
        step();
`ifdef ARB_WR_PRIORITY_EN
        chk("cont_first_wr", 1'b1, 1'b0, 3'd2, 8'h22, 1'b0, 8'h00, 3'd2, 1'b0);
        step();
        chk("cont_idle2", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 3'd3, 1'b0);
        step();
        chk("cont_then_rd", 1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 8'h00, 3'd3, 1'b0);
        step();
        chk("cont_ack", 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 8'hA5, 3'd3, 1'b0);
        rd_req = 1'b0; step();
`else
        chk("cont_first_rd", 1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 8'h00, 3'd2, 1'b0);
        step();
        chk("cont_ack", 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 8'hA5, 3'd2, 1'b0);
        rd_req = 1'b0; step();
        chk("cont_idle2", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 3'd2, 1'b0);
        step();
        chk("cont_then_wr", 1'b1, 1'b0, 3'd2, 8'h22, 1'b0, 8'h00, 3'd2, 1'b0);
        step();
`endif
        chk("cont_end", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 3'd3, 1'b0);

        // Nine spaced writes wrap the pointer once.
        do_reset();
        chk("reset2", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
        for (int v = 1; v <= 9; v++) begin
            wr_req = 1'b1; wr_data = 8'(v); step();
            wr_req = 1'b0; step();
            step();
        end
        chk_mem("wrap_ram0", 0, 8'd9);
        for (int a = 1; a < 8; a++)
            chk_mem($sformatf("wrap_ram%0d", a), a, 8'(a + 1));
        chk("wrap_ptr", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 3'd1, 1'b0);

        // Three writes during a read: the third hits a full buffer and is dropped.
        do_reset();
        rd_req = 1'b1; rd_addr = 3'd2; step();
        chk("ovf_rd", 1'b0, 1'b1, 3'd2, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
        wr_req = 1'b1; wr_data = 8'hAA; step();
        chk("ovf_ack", 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 8'h03, 3'd0, 1'b0);
        wr_data = 8'hBB; rd_req = 1'b0; step();
        chk("ovf_idle", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
        wr_data = 8'hCC; step();
        chk("ovf_wr0", 1'b1, 1'b0, 3'd0, 8'hAA, 1'b0, 8'h00, 3'd0, 1'b1);
        wr_req = 1'b0; step();
        step();
        chk("ovf_wr1", 1'b1, 1'b0, 3'd1, 8'hBB, 1'b0, 8'h00, 3'd1, 1'b1);
        for (int k = 0; k < 4; k++) step();
        chk("ovf_sticky", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 3'd2, 1'b1);
        chk_mem("ovf_ram0", 0, 8'hAA);
        chk_mem("ovf_ram1", 1, 8'hBB);
        chk_mem("ovf_ram2", 2, 8'h03);

        // Reset landing on the RD state cancels the read.
        rd_req = 1'b1; rd_addr = 3'd4; step();
        chk("rst_rd", 1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 8'h00, 3'd2, 1'b1);
        reset_n = 1'b0; rd_req = 1'b0; step();
        chk("rst_in", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rst_after%0d", k), 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arb.md
Name: ram_port_arb

Overview:
- Arbitrates one single-port synchronous RAM between two requesters:
  - the averaging write path, which pulses wr_req once per averaged result;
  - a host read requester.
- Buffers up to 2 pending writes and generates sequential write addresses that wrap.
- Returns host read data with a one-cycle ack.
- Sits between the FIFO/averager controller and the result RAM.

Parameters:
- ADDR_W, 3, RAM address width (2^ADDR_W entries).
- DATA_W, 8, RAM/data word width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- wr_req  in  1  one-cycle write request pulse from the averaging controller.
- wr_data  in  DATA_W  write data; valid with wr_req.
- rd_req  in  1  host read request (level).
- rd_addr  in  ADDR_W  host read address; stable while rd_req is high.
- rd_ack  out  1  one-cycle pulse; rd_data valid.
- rd_data  out  DATA_W  equals ram_rdata while rd_ack=1, else 0.
- ram_we  out  1  RAM write enable.
- ram_re  out  1  RAM read enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid the cycle after ram_re.
- wr_ptr  out  ADDR_W  next RAM write address.
- overflow  out  1  sticky: a wr_req was dropped.

Behaviour:
Reset:
- Applies only on a clk edge with reset_n=0.
- Outputs: ram_we=0, ram_re=0, rd_ack=0, rd_data=0, ram_addr=0, ram_wdata=0, wr_ptr=0, overflow=0.
- Internal: state=IDLE, buffer empty, last_grant=READ.

Write buffer:
- 2-entry FIFO with a count of 0..2; pushed on wr_req.
- wr_req while count=2 and no pop that cycle: the word is dropped, overflow is set and stays set until reset.
- Push and pop in the same cycle at count=2: both are accepted and count stays 2.

FSM (Moore outputs decoded from state):
- IDLE:
  - all enables 0.
  - If a write is pending and (rd_req=0 or last_grant=READ), go to WR.
  - Else if rd_req=1, capture rd_addr and go to RD.
  - Else stay in IDLE.
- WR:
  - ram_we=1, ram_addr=wr_ptr, ram_wdata=buffer head.
  - On exit: pop the buffer, wr_ptr+1 modulo 2^ADDR_W (7 -> 0 at the default), last_grant=WRITE. Go to IDLE.
- RD:
  - ram_re=1, ram_addr=captured address. Go to RDATA.
- RDATA:
  - rd_ack=1, rd_data=ram_rdata, last_grant=READ. Go to IDLE.

Latency:
- wr_req in cycle N into an empty buffer with the FSM in IDLE: ram_we in cycle N+2.
- rd_req seen in an IDLE cycle M with no competing write: ram_re in M+1, rd_ack in M+2.

Handshake:
- rd_req is sampled only in IDLE.
- The requester must deassert rd_req in the rd_ack cycle; otherwise a second read is issued.

Contention:
- When both requesters are pending, grants alternate, so a read waits for at most one write.
- Back-to-back writes with no read each take 2 cycles (WR, IDLE).

Reset mid-operation:
- A write whose WR cycle coincides with the reset edge still drives ram_we in that cycle.
- After reset the buffer is empty and the pointer is 0.
- An in-flight read gets no rd_ack; the host must reissue it.

Optional Feature:
- Macro: ARB_WR_PRIORITY_EN.
- Defined: fixed priority. A pending write always wins in IDLE and last_grant is ignored; reads are served only when the buffer is empty.
- Undefined: alternating grant as described above.

Test Plan:
- Reset, then wr_req with wr_data=8'hA5 in cycle 5 -> ram_we=1, ram_addr=0, ram_wdata=8'hA5 in cycle 7; wr_ptr=1 afterwards.
- Preload RAM[3]=8'h3C; rd_req=1, rd_addr=3 in an IDLE cycle 10 -> ram_re=1 and ram_addr=3 in cycle 11; rd_ack=1 and rd_data=8'h3C in cycle 12; rd_data=0 in cycle 13.
- 9 writes of values 1..9, spaced so none is dropped -> RAM[0]=9, RAM[1..7]=2..8, wr_ptr=1, overflow=0.
- Hold the FSM serving continuous reads while issuing 3 wr_req pulses -> third word dropped, overflow=1 and stays 1 until reset; the two buffered words land at addresses 0 and 1.
- Write pending and rd_req asserted together with last_grant=WRITE -> RD granted first, then WR. Repeat with ARB_WR_PRIORITY_EN defined -> WR granted first.
- reset_n=0 during the RD state -> no rd_ack; after release all outputs are 0, overflow=0, wr_ptr=0.
